// File: rtl/layer_train_sequencer_if.sv
// Sample-stream handshake between a sample producer and layer_train_sequencer.
// The producer drives s_valid/s_in/s_expected/s_last; the sequencer returns s_ready.
interface layer_train_sequencer_if #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 16,
  parameter int unsigned W = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [N-1:0][W-1:0]   s_in;
  logic [M-1:0][W-1:0]   s_expected;
  logic                  s_last;

  modport master (
    output s_valid,
    output s_in,
    output s_expected,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_in,
    input  s_expected,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/layer_train_sequencer.sv
// Feeds queued training samples to a learning layer one at a time and tracks per-epoch error.
// Optional macro SEQ_ERROR_ACCUM_EN enables the absolute-error accumulator and err_sum.
module layer_train_sequencer #(
  parameter int unsigned N      = 16,
  parameter int unsigned M      = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned W      = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      learn_mode,
  layer_train_sequencer_if.slave    s,
  output logic                      layer_valid,
  output logic                      layer_learn,
  output logic [N-1:0][W-1:0]       layer_in,
  output logic [M-1:0][W-1:0]       layer_expected_out,
  input  logic [M-1:0][W-1:0]       layer_out,
  output logic [W+7:0]              err_sum,
  output logic [15:0]               sample_count,
  output logic                      epoch_done,
  output logic                      busy
);

  localparam int unsigned ERRW  = W + 8;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned WaitW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPresent,
    StWait,
    StCapture
  } state_e;

  state_e state_q, state_d;

  // Sample FIFO storage and pointers.
  logic [N-1:0][W-1:0] fifo_in   [DEPTH];
  logic [M-1:0][W-1:0] fifo_exp  [DEPTH];
  logic                fifo_last [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                fifo_empty;
  logic                push, pop;

  logic [N-1:0][W-1:0] layer_in_q;
  logic [M-1:0][W-1:0] layer_exp_q;
  logic                last_q;
  logic                learn_q;
  logic [WaitW-1:0]    wait_cnt_q;
  logic [15:0]         sample_count_q;
  logic                capture;

  // s_ready comes from the registered count only, so it never sees the pop combinationally.
  assign s.s_ready  = (count_q != CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = s.s_valid && s.s_ready;
  assign pop        = (state_q == StLoad);
  assign capture    = (state_q == StCapture);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_in[wr_ptr_q]   <= s.s_in;
      fifo_exp[wr_ptr_q]  <= s.s_expected;
      fifo_last[wr_ptr_q] <= s.s_last;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (enable && !fifo_empty) state_d = StLoad;
      StLoad:    state_d = StPresent;
      StPresent: state_d = StWait;
      StWait:    if (wait_cnt_q == WaitW'(SETTLE - 1)) state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == StWait) begin
      wait_cnt_q <= wait_cnt_q + WaitW'(1);
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Held sample: stable from one LOAD until the next.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      layer_in_q  <= '0;
      layer_exp_q <= '0;
      last_q      <= 1'b0;
      learn_q     <= 1'b0;
    end else if (pop) begin
      layer_in_q  <= fifo_in[rd_ptr_q];
      layer_exp_q <= fifo_exp[rd_ptr_q];
      last_q      <= fifo_last[rd_ptr_q];
      learn_q     <= learn_mode;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_count_q <= '0;
    end else if (capture) begin
      if (last_q) begin
        sample_count_q <= '0;
      end else if (sample_count_q != 16'hFFFF) begin
        sample_count_q <= sample_count_q + 16'd1;
      end
    end
  end

`ifdef SEQ_ERROR_ACCUM_EN
  localparam int unsigned SumW = ERRW + 1;

  logic [ERRW-1:0] acc_q, err_sum_q, acc_next;
  logic [SumW-1:0] err_add, acc_sum;

  always_comb begin
    err_add = '0;
    for (int k = 0; k < int'(M); k++) begin
      if (layer_out[k] > layer_exp_q[k]) begin
        err_add = err_add + SumW'(layer_out[k] - layer_exp_q[k]);
      end else begin
        err_add = err_add + SumW'(layer_exp_q[k] - layer_out[k]);
      end
    end
    acc_sum  = {1'b0, acc_q} + err_add;
    acc_next = acc_sum[ERRW] ? '1 : acc_sum[ERRW-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q     <= '0;
      err_sum_q <= '0;
    end else if (capture) begin
      if (last_q) begin
        err_sum_q <= acc_next;
        acc_q     <= '0;
      end else begin
        acc_q <= acc_next;
      end
    end
  end

  assign err_sum = err_sum_q;
`else
  logic unused_layer_out;
  assign unused_layer_out = ^layer_out;
  assign err_sum          = '0;
`endif

  assign layer_valid        = (state_q == StPresent);
  assign layer_learn        = (state_q == StPresent) && learn_q;
  assign layer_in           = layer_in_q;
  assign layer_expected_out = layer_exp_q;
  assign sample_count       = sample_count_q;
  assign epoch_done         = capture && last_q;
  assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_layer_train_sequencer.sv
// Directed self-checking bench for layer_train_sequencer (default parameters).
// Expected err_sum follows whether SEQ_ERROR_ACCUM_EN is defined for the build.
module tb_layer_train_sequencer;
  localparam int unsigned N = 16;
  localparam int unsigned M = 16;
  localparam int unsigned W = 8;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                enable;
  logic                learn_mode;
  logic                layer_valid, layer_learn;
  logic [N-1:0][W-1:0] layer_in;
  logic [M-1:0][W-1:0] layer_expected_out;
  logic [M-1:0][W-1:0] layer_out;
  logic [W+7:0]        err_sum;
  logic [15:0]         sample_count;
  logic                epoch_done, busy;

  layer_train_sequencer_if #(.N(N), .M(M), .W(W)) sif ();

  layer_train_sequencer #(.N(N), .M(M), .DEPTH(4), .SETTLE(2), .W(W)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .enable             (enable),
    .learn_mode         (learn_mode),
    .s                  (sif),
    .layer_valid        (layer_valid),
    .layer_learn        (layer_learn),
    .layer_in           (layer_in),
    .layer_expected_out (layer_expected_out),
    .layer_out          (layer_out),
    .err_sum            (err_sum),
    .sample_count       (sample_count),
    .epoch_done         (epoch_done),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int strobes  = 0;
  int epochs   = 0;
  logic [7:0]  tag_q   [$];
  logic        learn_q [$];
  logic [15:0] cnt_q   [$];

  always @(negedge clock) begin
    if (layer_valid) begin
      strobes++;
      tag_q.push_back(layer_in[0]);
      learn_q.push_back(layer_learn);
      cnt_q.push_back(sample_count);
    end
    if (epoch_done) epochs++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    tag_q.delete();
    learn_q.delete();
    cnt_q.delete();
  endtask

  task automatic do_reset();
    sif.s_valid = 1'b0;
    reset_n     = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic set_sample(input logic [7:0] tag, input logic last, input logic [7:0] e5);
    sif.s_in       = {N{tag}};
    sif.s_expected = {M{tag}};
    sif.s_expected[5] = e5;
    sif.s_last     = last;
  endtask

  // Offers one sample for exactly one edge; reports whether it was accepted.
  task automatic push(input logic [7:0] tag, input logic last, output logic ok);
    set_sample(tag, last, tag);
    sif.s_valid = 1'b1;
    ok = sif.s_ready;
    tick();
    sif.s_valid = 1'b0;
  endtask

  // Holds a sample until accepted, with a cycle bound.
  task automatic push_wait(input logic [7:0] tag, input logic last, input logic [7:0] e5,
                           output logic ok);
    int t = 0;
    set_sample(tag, last, e5);
    sif.s_valid = 1'b1;
    while (!sif.s_ready && t < 40) begin
      tick();
      t++;
    end
    ok = (t < 40);
    tick();
    sif.s_valid = 1'b0;
  endtask

  initial begin
    logic ok;
    int   acc;
    int   base_s, base_e;

    reset_n = 1'b0; enable = 1'b0; learn_mode = 1'b0;
    sif.s_valid = 1'b0; sif.s_in = '0; sif.s_expected = '0; sif.s_last = 1'b0;
    layer_out = '0;

    // Reset state and single-sample latency.
    do_reset();
    check("rst_ready", sif.s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", layer_valid, 0);
    check("rst_learn", layer_learn, 0);
    check("rst_layer_in", layer_in, 0);
    check("rst_layer_exp", layer_expected_out, 0);
    check("rst_err_sum", err_sum, 0);
    check("rst_count", sample_count, 0);
    check("rst_epoch", epoch_done, 0);

    enable = 1'b1; learn_mode = 1'b1;
    push(8'h5A, 1'b1, ok);                     // edge E
    check("lat_idle_after_E", busy, 0);
    tick();                                    // E+1: LOAD
    check("lat_load_busy", busy, 1);
    check("lat_load_valid", layer_valid, 0);
    tick();                                    // E+2: PRESENT
    check("lat_present_valid", layer_valid, 1);
    check("lat_present_learn", layer_learn, 1);
    check("lat_present_in", layer_in[3], 8'h5A);
    check("lat_present_exp", layer_expected_out[7], 8'h5A);
    tick();                                    // E+3: WAIT
    check("lat_wait_valid", layer_valid, 0);
    tick();                                    // E+4
    check("lat_wait2_epoch", epoch_done, 0);
    tick();                                    // E+5: CAPTURE
    check("lat_capture_epoch", epoch_done, 1);
    tick();                                    // E+6: IDLE
    check("lat_epoch_pulse_end", epoch_done, 0);
    check("lat_count_cleared", sample_count, 0);
    check("lat_busy_done", busy, 0);
    check("lat_in_stable", layer_in[0], 8'h5A);

    // FIFO fill with enable low, overflow push ignored.
    do_reset();
    enable = 1'b0;
    clear_logs();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      push(8'(i + 1), 1'b0, ok);
      if (ok) acc++;
    end
    check("full_accepted", acc, 4);
    check("full_ready_low", sif.s_ready, 0);
    check("full_idle", busy, 0);
    base_s = strobes;
    enable = 1'b1;
    repeat (40) tick();
    check("full_strobes", strobes - base_s, 4);
    check("full_tag_count", tag_q.size(), 4);
    for (int i = 0; i < 4 && i < tag_q.size(); i++) check("full_order", tag_q[i], 8'(i + 1));
    check("full_ready_back", sif.s_ready, 1);
    check("full_count", sample_count, 4);

    // Error accumulation: 3 samples, 3 LSB off on one output each.
    do_reset();
    layer_out = {M{8'd50}};
    enable = 1'b1; learn_mode = 1'b0;
    base_e = epochs;
    push_wait(8'd50, 1'b0, 8'd53, ok);
    check("err_push0", ok, 1);
    push_wait(8'd50, 1'b0, 8'd53, ok);
    check("err_push1", ok, 1);
    push_wait(8'd50, 1'b1, 8'd53, ok);
    check("err_push2", ok, 1);
    repeat (30) tick();
`ifdef SEQ_ERROR_ACCUM_EN
    check("err_sum", err_sum, 9);
`else
    check("err_sum", err_sum, 0);
`endif
    check("err_epochs", epochs - base_e, 1);
    check("err_count_cleared", sample_count, 0);

    // learn_mode toggled during WAIT.
    do_reset();
    clear_logs();
    enable = 1'b1; learn_mode = 1'b1;
    push(8'h21, 1'b0, ok);                     // E
    repeat (3) tick();                         // E+3: WAIT
    learn_mode = 1'b0;
    push(8'h22, 1'b0, ok);
    repeat (20) tick();
    check("learn_strobes", learn_q.size(), 2);
    if (learn_q.size() == 2) begin
      check("learn_first", learn_q[0], 1);
      check("learn_second", learn_q[1], 0);
    end

    // Reset during WAIT with two samples queued.
    do_reset();
    enable = 1'b1;
    base_s = strobes;
    base_e = epochs;
    push(8'h31, 1'b1, ok);                     // E
    push(8'h32, 1'b0, ok);                     // E+1, LOAD cycle
    check("mid_push_in_load", ok, 1);
    push(8'h33, 1'b0, ok);                     // E+2
    tick();                                    // E+3: WAIT
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", sif.s_ready, 1);
    check("mid_rst_layer_in", layer_in, 0);
    repeat (25) tick();
    check("mid_strobes", strobes - base_s, 1);
    check("mid_epochs", epochs - base_e, 0);
    check("mid_count", sample_count, 0);

    // Continuous pushes across pointer wrap.
    do_reset();
    clear_logs();
    enable = 1'b1;
    base_s = strobes;
    for (int i = 0; i < 9; i++) begin
      push_wait(8'(8'h40 + i), 1'b0, 8'(8'h40 + i), ok);
      check("wrap_push", ok, 1);
    end
    repeat (40) tick();
    check("wrap_strobes", strobes - base_s, 9);
    check("wrap_tags", tag_q.size(), 9);
    for (int i = 0; i < 9 && i < tag_q.size(); i++) begin
      check("wrap_order", tag_q[i], 8'(8'h40 + i));
      check("wrap_step_count", cnt_q[i], 16'(i));
    end
    check("wrap_final_count", sample_count, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
